// File: rtl/dino_pkg.sv
// Shared constants and state encoding for the dinosaur player-motion stage.
// The display controller imports the same ground/sprite geometry, so both blocks agree on where the ground is.
// Contents: dino_state_t (RUN/RISE/FALL), GROUND_LINE, DINO_W, DINO_H, GROUND_Y.
package dino_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_RISE = 2'd1,
    ST_FALL = 2'd2
  } dino_state_t;

  localparam int GROUND_LINE = 335;
  localparam int DINO_W      = 60;
  localparam int DINO_H      = 60;
  // Sprite top row when the dinosaur stands on the ground line.
  localparam int GROUND_Y    = GROUND_LINE - DINO_H;

endpackage

// File: rtl/dino_jump_ctrl_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector.
// Latency: pulse is high for one clk cycle, combinationally after the 2nd capturing edge.
// Ports: clk, reset_n (async active-low), d (async level in), pulse (one-cycle rising-edge strobe).
module sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic pulse
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

  assign pulse = sync & ~prev;

endmodule

// File: rtl/dino_jump_ctrl.sv
// Player-motion stage: turns up/down buttons into the dinosaur sprite position, one physics step per frame.
// Latency: dino_y/airborne update on the 3rd clk edge after screenEnd is first sampled high.
// Ports: clk, reset_n, screenEnd, up, down, game_on, game_over in; dino_x, dino_y, airborne out.
// Optional feature macro DINO_FAST_FALL_EN: holding down while airborne doubles gravity.
module dino_jump_ctrl #(
  parameter int DINO_X   = 50,
  parameter int GROUND_Y = dino_pkg::GROUND_Y,
  parameter int JUMP_V   = 12,
  parameter int GRAVITY  = 1,
  parameter int CEIL_Y   = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        screenEnd,
  input  logic        up,
  input  logic        down,
  input  logic        game_on,
  input  logic        game_over,
  output logic [31:0] dino_x,
  output logic [31:0] dino_y,
  output logic        airborne
);

  import dino_pkg::*;

  localparam logic signed [10:0] GROUND_Y_S = 11'(GROUND_Y);
  localparam logic signed [10:0] CEIL_Y_S   = 11'(CEIL_Y);
  localparam logic signed [7:0]  JUMP_V_S   = 8'(JUMP_V);
  localparam logic signed [7:0]  GRAV_S     = 8'(GRAVITY);

  logic frame_tick;
  logic up_pulse;
  logic active;

  dino_state_t        state;
  logic signed [10:0] y_q;
  logic signed [7:0]  vel_q;
  logic               req;
  logic               airborne_q;

  logic signed [7:0]  grav;
  logic signed [10:0] y_nxt;
  logic signed [7:0]  vel_nxt;

  sync_edge u_frame_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (screenEnd),
    .pulse   (frame_tick)
  );

  sync_edge u_up_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (up),
    .pulse   (up_pulse)
  );

`ifdef DINO_FAST_FALL_EN
  localparam logic signed [7:0] GRAV2_S = 8'(2 * GRAVITY);

  logic down_meta;
  logic down_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      down_meta <= 1'b0;
      down_sync <= 1'b0;
    end else begin
      down_meta <= down;
      down_sync <= down_meta;
    end
  end

  assign grav = (down_sync && (state != ST_RUN)) ? GRAV2_S : GRAV_S;
`else
  logic unused_down;
  assign unused_down = down;
  assign grav        = GRAV_S;
`endif

  assign active = game_on & ~game_over;

  // Velocity is sign-extended so a falling (negative) velocity moves y downward.
  assign y_nxt   = y_q - {{3{vel_q[7]}}, vel_q};
  assign vel_nxt = vel_q - grav;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_RUN;
      y_q        <= GROUND_Y_S;
      vel_q      <= '0;
      req        <= 1'b0;
      airborne_q <= 1'b0;
    end else if (active && frame_tick) begin
      unique case (state)
        ST_RUN: begin
          // Take-off only sets velocity; the first displacement happens on the next tick.
          if (req || up_pulse) begin
            vel_q      <= JUMP_V_S;
            state      <= ST_RISE;
            airborne_q <= 1'b1;
            req        <= 1'b0;
          end
        end
        default: begin
          if (y_nxt >= GROUND_Y_S) begin
            y_q        <= GROUND_Y_S;
            vel_q      <= '0;
            state      <= ST_RUN;
            airborne_q <= 1'b0;
          end else begin
            y_q        <= (y_nxt < CEIL_Y_S) ? CEIL_Y_S : y_nxt;
            vel_q      <= vel_nxt;
            state      <= (vel_nxt > 8'sd0) ? ST_RISE : ST_FALL;
            airborne_q <= 1'b1;
          end
        end
      endcase
    end else if (active && up_pulse && (state == ST_RUN)) begin
      // Press between frames is remembered until the next tick; presses while airborne are dropped.
      req <= 1'b1;
    end
  end

  logic unused_y_msb;
  assign unused_y_msb = y_q[10];

  assign dino_x   = 32'(DINO_X);
  assign dino_y   = {22'd0, y_q[9:0]};
  assign airborne = airborne_q;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
module tb_dino_jump_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        screenEnd = 1'b0;
  logic        up = 1'b0;
  logic        down = 1'b0;
  logic        game_on = 1'b0;
  logic        game_over = 1'b0;
  logic [31:0] dino_x;
  logic [31:0] dino_y;
  logic        airborne;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int pre_y;
    bit pre_air;
    int post_y;
    bit post_air;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  int cur_y = 275;
  bit cur_air = 1'b0;

  // Hand-computed default trajectory: entry k is dino_y after tick k (tick 0 = take-off).
  int traj [0:25] = '{275, 263, 252, 242, 233, 225, 218, 212, 207, 203, 200, 198, 197,
                      197, 198, 200, 203, 207, 212, 218, 225, 233, 242, 252, 263, 275};
  // Fast-fall trajectory with down held from tick 13: entries for ticks 13..22.
  int fast_traj [0:9] = '{197, 199, 203, 209, 217, 227, 239, 253, 269, 275};

  dino_jump_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .screenEnd (screenEnd),
    .up        (up),
    .down      (down),
    .game_on   (game_on),
    .game_over (game_over),
    .dino_x    (dino_x),
    .dino_y    (dino_y),
    .airborne  (airborne)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int got_y, input bit got_air,
                       input int want_y, input bit want_air);
    checks++;
    if (got_y != want_y || got_air != want_air) begin
      failures++;
      $display("FAIL %s: got y=%0d air=%0b, want y=%0d air=%0b", name, got_y, got_air, want_y, want_air);
    end
  endtask

  // Monitor: each frame, verify the old value still holds after 2 edges and the new one after the 3rd.
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(posedge screenEnd);
      repeat (2) @(posedge clk);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL no_expectation: frame seen with empty scoreboard");
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, "_hold"}, int'(dino_y), airborne, e.pre_y, e.pre_air);
        checks++;
        if (dino_x != 32'd50) begin
          failures++;
          $display("FAIL %s_x: got dino_x=%0d, want 50", t, dino_x);
        end
        @(posedge clk);
        @(negedge clk);
        check(t, int'(dino_y), airborne, e.post_y, e.post_air);
      end
    end
  end

  task automatic frame(input string tag, input int y, input bit air, input bit with_up);
    exp_t e;
    @(negedge clk);
    e.pre_y    = cur_y;
    e.pre_air  = cur_air;
    e.post_y   = y;
    e.post_air = air;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    screenEnd = 1'b1;
    if (with_up) up = 1'b1;
    repeat (4) @(negedge clk);
    screenEnd = 1'b0;
    up = 1'b0;
    repeat (12) @(negedge clk);
    cur_y   = y;
    cur_air = air;
  endtask

  task automatic press_up();
    @(negedge clk);
    up = 1'b1;
    repeat (3) @(negedge clk);
    up = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cur_y   = 275;
    cur_air = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic jump_ticks(input string name, input int first, input int last);
    for (int k = first; k <= last; k++)
      frame($sformatf("%s_t%0d", name, k), traj[k], (k != 25), 1'b0);
  endtask

  initial begin
    // Reset held with up pressed and frames running: nothing may move.
    up = 1'b1;
    frame("rst_hold_a", 275, 1'b0, 1'b0);
    up = 1'b1;
    frame("rst_hold_b", 275, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    up = 1'b1;
    repeat (4) @(negedge clk);
    up = 1'b0;
    // Game not started: a press must not launch nor be remembered.
    press_up();
    frame("idle_a", 275, 1'b0, 1'b0);
    frame("idle_b", 275, 1'b0, 1'b0);
    game_on = 1'b1;
    frame("start_no_req", 275, 1'b0, 1'b0);

    // Full jump.
    press_up();
    jump_ticks("jump", 0, 25);
    frame("jump_after", 275, 1'b0, 1'b0);

    // Second press at tick 5 is ignored; no jump after landing without a fresh press.
    press_up();
    jump_ticks("dbl", 0, 5);
    press_up();
    jump_ticks("dbl", 6, 25);
    frame("dbl_after_a", 275, 1'b0, 1'b0);
    frame("dbl_after_b", 275, 1'b0, 1'b0);

    // game_over mid-air freezes the sprite; reset mid-air returns to ground.
    press_up();
    jump_ticks("go", 0, 8);
    game_over = 1'b1;
    for (int k = 0; k < 10; k++)
      frame($sformatf("go_frozen_%0d", k), traj[8], 1'b1, 1'b0);
    apply_reset();
    game_over = 1'b0;
    frame("rst_midair", 275, 1'b0, 1'b0);

    // Button edge and frame edge in the same cycle: take-off on that tick.
    frame("simul_t0", 275, 1'b1, 1'b1);
    jump_ticks("simul", 1, 25);

    // Down held from tick 13.
    press_up();
    jump_ticks("down", 0, 12);
    down = 1'b1;
`ifdef DINO_FAST_FALL_EN
    for (int k = 0; k < 10; k++)
      frame($sformatf("fast_t%0d", k + 13), fast_traj[k], (k != 9), 1'b0);
`else
    jump_ticks("down", 13, 25);
`endif
    down = 1'b0;
    frame("down_after", 275, 1'b0, 1'b0);

    repeat (10) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
